linked_list_pop_scheduler: RTL

Round-robin drain stage placed directly downstream of `linked_list_fifo`. It scans the sub-FIFOs and issues single-cycle `pop`/`pop_fifo` requests only to non-empty, enabled sub-FIFOs. It captures the one-cycle-latency `q` data, tagged with its source FIFO index, into a small output buffer. The buffer is drained by a valid/ready consumer, and pops are credit-limited so that no popped word is ever dropped.

---
 rtl/linked_list_pop_scheduler.sv | 120 ++++++++++++
 1 files changed

// File: rtl/linked_list_pop_scheduler.sv
// Round-robin drain stage for a linked-list FIFO: issues credit-limited pops to
// non-empty enabled sub-FIFOs and buffers the tagged read data for a valid/ready consumer.
module linked_list_pop_scheduler #(
    parameter int WIDTH      = 8,
    parameter int FIFOS      = 8,
    parameter int LOG2_FIFOS = (FIFOS > 2) ? $clog2(FIFOS) : 1,
    parameter int BURST      = 4,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [FIFOS-1:0]      fifo_mask,
    output logic                  ll_pop,
    output logic [LOG2_FIFOS-1:0] ll_pop_fifo,
    input  logic                  ll_empty,
    input  logic [WIDTH-1:0]      ll_q,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [LOG2_FIFOS-1:0] out_fifo,
    input  logic                  out_ready
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = AW + 1;

    logic [LOG2_FIFOS-1:0] ptr;
    logic [LOG2_FIFOS-1:0] ptr_next;
    logic [LOG2_FIFOS-1:0] tag_d1;
    logic [3:0]            bcnt;
    logic                  inflight;
    logic                  credit;
    logic                  pop_issue;
    logic                  last_of_burst;

    logic [CW-1:0]         wr_ptr;
    logic [CW-1:0]         rd_ptr;
    logic [CW-1:0]         rd_next;
    logic [CW-1:0]         count;
    logic [CW:0]           occupancy;
    logic                  do_write;
    logic                  do_read;

    logic [WIDTH-1:0]      ob_data [OUT_DEPTH];
    logic [LOG2_FIFOS-1:0] ob_tag  [OUT_DEPTH];
    logic [WIDTH-1:0]      head_data;
    logic [LOG2_FIFOS-1:0] head_tag;

    // The word already in flight reserves a slot, so a write can never find the buffer full.
    assign count         = wr_ptr - rd_ptr;
    assign occupancy     = {1'b0, count} + (CW + 1)'(inflight);
    assign credit        = occupancy < (CW + 1)'(OUT_DEPTH);
    assign pop_issue     = rst_n & en & fifo_mask[ptr] & ~ll_empty & credit;
    assign last_of_burst = (bcnt == 4'(BURST - 1));
    assign ptr_next      = (ptr == LOG2_FIFOS'(FIFOS - 1)) ? '0 : ptr + 1'b1;

    assign do_write = inflight;
    assign do_read  = (count != '0) & out_ready;
    assign rd_next  = rd_ptr + CW'(do_read);

    assign ll_pop      = pop_issue;
    assign ll_pop_fifo = ptr;
    assign out_valid   = (count != '0);
    assign out_data    = head_data;
    assign out_fifo    = head_tag;

    // Any cycle without a pop forfeits the rest of the visit, keeping the scan fair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            bcnt     <= '0;
            inflight <= 1'b0;
            tag_d1   <= '0;
        end else begin
            inflight <= pop_issue;
            if (pop_issue) begin
                tag_d1 <= ptr;
            end
            if (pop_issue && !last_of_burst) begin
                bcnt <= bcnt + 4'd1;
            end else begin
                bcnt <= '0;
                ptr  <= ptr_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                ob_data[i] <= '0;
                ob_tag[i]  <= '0;
            end
        end else begin
            if (do_write) begin
                ob_data[wr_ptr[AW-1:0]] <= ll_q;
                ob_tag[wr_ptr[AW-1:0]]  <= tag_d1;
            end
            wr_ptr <= wr_ptr + CW'(do_write);
            rd_ptr <= rd_next;
        end
    end

    // Head registers preload the next entry so the outputs only move on a handshake or first fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_data <= '0;
            head_tag  <= '0;
        end else if (do_write && (rd_next == wr_ptr)) begin
            head_data <= ll_q;
            head_tag  <= tag_d1;
        end else if (rd_next != wr_ptr) begin
            head_data <= ob_data[rd_next[AW-1:0]];
            head_tag  <= ob_tag[rd_next[AW-1:0]];
        end
    end

endmodule
